ppi_ctrl_seq: RTL

- Control sequencer for the 8255A-style PPI. Decodes the host bus (nCs/nRd/nWr/A) in a single clock domain and owns the control-word register.
- Executes port-C bit set/reset (BSR) commands.
- Runs the mode-1 strobed-input handshake for port A, driving handshake bits onto port C.
- Sits between the host bus and the port A/B/C datapath blocks. Those blocks consume `controlword`, `pc_out`, `pc_oe` and `pa_latch`.

---
 rtl/ppi_ctrl_seq.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/ppi_ctrl_seq.sv
// rtl/ppi_ctrl_seq.sv - 8255A-style PPI control sequencer: bus decode, control word, BSR, mode-1 port A handshake.
// Optional mode-1 output OBFa/ACKa handshake enabled by defining PPI_MODE1_OUT_EN.
module ppi_ctrl_seq #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CW_RESET    = 8'h9B
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       nCs,
  input  logic       nRd,
  input  logic       nWr,
  input  logic [1:0] A,
  input  logic [7:0] din,
  input  logic [7:0] pa_in,
  input  logic [7:0] pc_in,
  output logic [7:0] dout,
  output logic       dout_oe,
  output logic [7:0] controlword,
  output logic [7:0] pc_out,
  output logic [7:0] pc_oe,
  output logic [7:0] pa_latch,
  output logic       intr_a
);

  typedef enum logic [1:0] {IDLE, STROBE, FULL} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] rd_sync, wr_sync, stb_sync;
  logic                   rd_p, wr_p, stb_p;
  logic                   rd_s, wr_s, stb_s;
  logic                   rd_fall, rd_rise, wr_rise, stb_fall, stb_rise;
  logic [7:0]             pc_reg;
  logic                   intea, ibfa, stb_pend, nobfa;
  logic                   m1in, m1out, wr_commit, pa_sel, rd_act;
  logic                   bsr_inte, bsr_owned;
  logic [2:0]             bsr_bit;
  logic [7:0]             rd_data;
  logic                   ack_fall, ack_rise;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      rd_sync  <= '1;
      wr_sync  <= '1;
      stb_sync <= '1;
      rd_p     <= 1'b1;
      wr_p     <= 1'b1;
      stb_p    <= 1'b1;
    end else begin
      rd_sync  <= {rd_sync[SYNC_STAGES-2:0], nRd};
      wr_sync  <= {wr_sync[SYNC_STAGES-2:0], nWr};
      stb_sync <= {stb_sync[SYNC_STAGES-2:0], pc_in[4]};
      rd_p     <= rd_s;
      wr_p     <= wr_s;
      stb_p    <= stb_s;
    end
  end

  assign rd_s     = rd_sync[SYNC_STAGES-1];
  assign wr_s     = wr_sync[SYNC_STAGES-1];
  assign stb_s    = stb_sync[SYNC_STAGES-1];
  assign rd_fall  = ~rd_s & rd_p;
  assign rd_rise  = rd_s & ~rd_p;
  assign wr_rise  = wr_s & ~wr_p;
  assign stb_fall = ~stb_s & stb_p;
  assign stb_rise = stb_s & ~stb_p;

  assign m1in      = (controlword[6:5] == 2'b01) && controlword[4];
  assign wr_commit = wr_rise && !nCs;
  assign pa_sel    = !nCs && (A == 2'b00);
  assign rd_act    = !rd_s && !nCs && (A != 2'b11);
  assign bsr_bit   = din[3:1];

`ifdef PPI_MODE1_OUT_EN
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_p, ack_s;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      ack_sync <= '1;
      ack_p    <= 1'b1;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], pc_in[6]};
      ack_p    <= ack_s;
    end
  end

  assign ack_s    = ack_sync[SYNC_STAGES-1];
  assign ack_fall = ~ack_s & ack_p;
  assign ack_rise = ack_s & ~ack_p;
  assign m1out    = (controlword[6:5] == 2'b01) && !controlword[4];
`else
  assign ack_fall = 1'b0;
  assign ack_rise = 1'b0;
  assign m1out    = 1'b0;
  assign nobfa    = 1'b1;
`endif

  // INTEa lives behind a BSR address; handshake-owned bits refuse BSR writes.
  assign bsr_inte  = (m1in && bsr_bit == 3'd4) || (m1out && bsr_bit == 3'd6);
  assign bsr_owned = (m1in && (bsr_bit == 3'd3 || bsr_bit == 3'd5)) ||
                     (m1out && (bsr_bit == 3'd3 || bsr_bit == 3'd7));

  always_comb begin
    rd_data = 8'h00;
    case (A)
      2'b00: rd_data = m1in ? pa_latch : pa_in;
      2'b10: begin
        rd_data = pc_in;
        if (m1in) begin
          rd_data[3] = intr_a;
          rd_data[5] = ibfa;
        end
        if (m1out) begin
          rd_data[3] = intr_a;
          rd_data[7] = nobfa;
        end
      end
      default: rd_data = 8'h00;
    endcase
  end

  always_comb begin
    pc_out = pc_reg;
    pc_oe  = {{4{~controlword[3]}}, {4{~controlword[0]}}};
    if (m1in) begin
      pc_out[5] = ibfa;
      pc_out[3] = intr_a;
      pc_oe[5]  = 1'b1;
      pc_oe[4]  = 1'b0;
      pc_oe[3]  = 1'b1;
    end
    if (m1out) begin
      pc_out[7] = nobfa;
      pc_out[3] = intr_a;
      pc_oe[7]  = 1'b1;
      pc_oe[6]  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      controlword <= CW_RESET;
      pc_reg      <= 8'h00;
      pa_latch    <= 8'h00;
      intea       <= 1'b0;
      ibfa        <= 1'b0;
      intr_a      <= 1'b0;
      stb_pend    <= 1'b0;
      state       <= IDLE;
      dout        <= 8'h00;
      dout_oe     <= 1'b0;
`ifdef PPI_MODE1_OUT_EN
      nobfa       <= 1'b1;
`endif
    end else begin
      dout_oe  <= rd_act;
      dout     <= rd_act ? rd_data : 8'h00;
      stb_pend <= 1'b0;
      if (m1in) begin
        case (state)
          IDLE: if (stb_fall || stb_pend) begin
            pa_latch <= pa_in;
            ibfa     <= 1'b1;
            state    <= STROBE;
          end
          STROBE: if (stb_rise) begin
            intr_a <= intea;
            state  <= FULL;
          end
          FULL: begin
            if (rd_fall && pa_sel) intr_a <= 1'b0;
            // A strobe landing on the read-completion cycle is replayed from IDLE.
            if (rd_rise && pa_sel) begin
              ibfa     <= 1'b0;
              state    <= IDLE;
              stb_pend <= stb_fall;
            end
          end
          default: state <= IDLE;
        endcase
      end
`ifdef PPI_MODE1_OUT_EN
      if (m1out) begin
        if (ack_fall) nobfa  <= 1'b1;
        if (ack_rise) intr_a <= intea;
      end
`endif
      if (wr_commit) begin
        if (A == 2'b11) begin
          if (din[7]) begin
            controlword <= din;
            pc_reg      <= 8'h00;
            intea       <= 1'b0;
            ibfa        <= 1'b0;
            intr_a      <= 1'b0;
            stb_pend    <= 1'b0;
            state       <= IDLE;
`ifdef PPI_MODE1_OUT_EN
            nobfa       <= 1'b1;
`endif
          end else if (bsr_inte) begin
            intea <= din[0];
          end else if (!bsr_owned) begin
            pc_reg[bsr_bit] <= din[0];
          end
        end else if (A == 2'b10) begin
          if (!controlword[3]) pc_reg[7:4] <= din[7:4];
          if (!controlword[0]) pc_reg[3:0] <= din[3:0];
        end
`ifdef PPI_MODE1_OUT_EN
        else if (A == 2'b00 && m1out) begin
          nobfa  <= 1'b0;
          intr_a <= 1'b0;
        end
`endif
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ack_fall ^ ack_rise;

endmodule
